// File: rtl/temporizador_displays.sv
// temporizador_displays -- countdown timer with five 7-segment displays.
//
// Loads a preset number of seconds (clamped to 59) and counts down in 1 ms
// steps to 00.000, then raises done. Start/pause are synchronized levels;
// their rising edges are the commands.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   preset_sec[5:0]          start value in seconds (tracked only in IDLE)
//   start, pause             command levels (rising edge = command)
//   ms[9:0], sec[5:0]        remaining time
//   running, done            registered state flags (RUN / DONE)
//   display_*[6:0]           active-low segments {g,f,e,d,c,b,a}
//
// Build option: define TEMPORIZADOR_BLINK_EN to blink the displays at 2 Hz
// while in DONE. Without it DONE shows a steady "00.000".

module temporizador_displays #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_DIV    = CLK_FREQ_HZ / 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] preset_sec,
  input  logic       start,
  input  logic       pause,
  output logic [9:0] ms,
  output logic [5:0] sec,
  output logic       running,
  output logic       done,
  output logic [6:0] display_sec_decenas,
  output logic [6:0] display_sec_unidades,
  output logic [6:0] display_ms_centenas,
  output logic [6:0] display_ms_decenas,
  output logic [6:0] display_ms_unidades
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t      state_q;
  logic [PW-1:0] presc_q;
  logic [9:0]  ms_q, ms_d;
  logic [5:0]  sec_q, sec_d;
  logic        running_q, done_q;
  logic        start_q, pause_q;
  logic        start_edge, pause_edge, tick, reach_zero;
  logic [5:0]  preset_cl;

  assign start_edge = start & ~start_q;
  assign pause_edge = pause & ~pause_q;
  assign tick       = (presc_q == PRE_MAX);
  assign preset_cl  = (preset_sec > 6'd59) ? 6'd59 : preset_sec;

  // Decremented time for a tick; borrowing from seconds reloads 999 ms.
  always_comb begin
    ms_d  = ms_q;
    sec_d = sec_q;
    if (ms_q != 10'd0) begin
      ms_d = ms_q - 10'd1;
    end else if (sec_q != 6'd0) begin
      sec_d = sec_q - 6'd1;
      ms_d  = 10'd999;
    end
  end
  assign reach_zero = (ms_d == 10'd0) && (sec_d == 6'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      ms_q      <= '0;
      sec_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
    end else begin
      start_q <= start;
      pause_q <= pause;
      case (state_q)
        IDLE: begin
          ms_q    <= '0;
          sec_q   <= preset_cl;
          presc_q <= '0;
          if (start_edge) begin
            if (preset_cl != 6'd0) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          // Pause wins over a coincident tick: prescaler and time hold.
          if (pause_edge) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end else if (tick) begin
            presc_q <= '0;
            ms_q    <= ms_d;
            sec_q   <= sec_d;
            if (reach_zero) begin
              state_q   <= DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        PAUSE: begin
          if (start_edge) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin // DONE
          ms_q  <= '0;
          sec_q <= '0;
          if (start_edge) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ms      = ms_q;
  assign sec     = sec_q;
  assign running = running_q;
  assign done    = done_q;

  logic blank;
`ifdef TEMPORIZADOR_BLINK_EN
  localparam int BLINK_DIV = CLK_FREQ_HZ / 4;
  localparam int BW        = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          blank_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != DONE) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_q <= '0;
      blank_q     <= ~blank_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end
  // Gate with done so the blank phase never leaks into the cycle after DONE.
  assign blank = blank_q & done_q;
`else
  assign blank = 1'b0;
`endif

  function automatic logic [6:0] seg7(input logic [9:0] v);
    case (v)
      10'd0:   seg7 = 7'b1000000;
      10'd1:   seg7 = 7'b1111001;
      10'd2:   seg7 = 7'b0100100;
      10'd3:   seg7 = 7'b0110000;
      10'd4:   seg7 = 7'b0011001;
      10'd5:   seg7 = 7'b0010010;
      10'd6:   seg7 = 7'b0000010;
      10'd7:   seg7 = 7'b1111000;
      10'd8:   seg7 = 7'b0000000;
      10'd9:   seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [9:0] ms_u, ms_t, ms_h, s_u, s_t;
  assign ms_u = ms_q % 10'd10;
  assign ms_t = (ms_q / 10'd10) % 10'd10;
  assign ms_h = ms_q / 10'd100;
  assign s_u  = {4'd0, sec_q % 6'd10};
  assign s_t  = {4'd0, sec_q / 6'd10};

  assign display_sec_decenas  = blank ? 7'h7F : seg7(s_t);
  assign display_sec_unidades = blank ? 7'h7F : seg7(s_u);
  assign display_ms_centenas  = blank ? 7'h7F : seg7(ms_h);
  assign display_ms_decenas   = blank ? 7'h7F : seg7(ms_t);
  assign display_ms_unidades  = blank ? 7'h7F : seg7(ms_u);

endmodule

// File: tb/tb_temporizador_displays.sv
// Directed bench for temporizador_displays with CLK_FREQ_HZ=10_000 (10-cycle
// tick). Inputs change and outputs are sampled on the falling clock edge.

module tb_temporizador_displays;

  logic       clk = 1'b0;
  logic       rst, start, pause;
  logic [5:0] preset_sec;
  logic [9:0] ms;
  logic [5:0] sec;
  logic       running, done;
  logic [6:0] dsd, dsu, dmc, dmd, dmu;
  logic [34:0] disp;

  localparam logic [34:0] ZERO5  = {5{7'b1000000}};
  localparam logic [34:0] BLANK5 = {5{7'b1111111}};

  int n_chk  = 0;
  int n_pass = 0;
  int c;

  temporizador_displays #(.CLK_FREQ_HZ(10_000)) dut (
    .clk(clk), .rst(rst), .preset_sec(preset_sec), .start(start), .pause(pause),
    .ms(ms), .sec(sec), .running(running), .done(done),
    .display_sec_decenas(dsd), .display_sec_unidades(dsu),
    .display_ms_centenas(dmc), .display_ms_decenas(dmd),
    .display_ms_unidades(dmu)
  );

  assign disp = {dsd, dsu, dmc, dmd, dmu};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; preset_sec = 6'd0;
    cyc(2);
    chk("rst_ms", ms, 0);
    chk("rst_sec", sec, 0);
    chk("rst_flags", {running, done}, 2'b00);
    chk("rst_disp", disp, ZERO5);
    rst = 1'b0;

    // Full countdown from 2 s
    preset_sec = 6'd2;
    cyc(1);
    chk("idle_preset", sec, 2);
    start = 1'b1;
    cyc(1);
    chk("run_entry", running, 1);
    cyc(9);
    chk("pre_tick", {sec, ms}, {6'd2, 10'd0});
    cyc(1);
    chk("first_tick", {sec, ms}, {6'd1, 10'd999});
    chk("disp_999", {dmc, dmd, dmu}, {3{7'b0010000}});
    c = 0;
    while (!done && c < 25000) begin cyc(1); c++; end
    chk("cd_len", c, 19990);
    chk("cd_flags", {running, done}, 2'b01);
    chk("done_disp", disp, ZERO5);
`ifdef TEMPORIZADOR_BLINK_EN
    cyc(2499);
    chk("blink_vis", disp, ZERO5);
    cyc(1);
    chk("blink_off", disp, BLANK5);
    cyc(2500);
    chk("blink_on2", disp, ZERO5);
`endif

    // Leave DONE, reload preset 1
    start = 1'b0; cyc(1);
    preset_sec = 6'd1; start = 1'b1;
    cyc(1);
    chk("done_to_idle", {running, done}, 2'b00);
    cyc(1);
    chk("reload_disp", {dsd, dsu, dmc}, {7'b1000000, 7'b1111001, 7'b1000000});

    // Pause / resume
    start = 1'b0; cyc(1);
    start = 1'b1; cyc(1);
    chk("p_run", running, 1);
    start = 1'b0;
    cyc(55);
    chk("p_before", {sec, ms}, {6'd0, 10'd995});
    pause = 1'b1;
    cyc(1);
    chk("p_enter", running, 0);
    cyc(200);
    chk("p_hold", ms, 995);
    chk("p_disp", dmu, 7'b0010010);
    pause = 1'b0; start = 1'b1;
    cyc(1);
    chk("p_resume", running, 1);
    c = 0;
    while (!done && c < 12000) begin cyc(1); c++; end
    chk("p_len", c, 9945);

    // Zero preset goes straight to DONE
    start = 1'b0; cyc(1);
    preset_sec = 6'd0; start = 1'b1; cyc(1);
    chk("z_idle", done, 0);
    start = 1'b0; cyc(1);
    start = 1'b1; cyc(1);
    chk("z_done", {running, done}, 2'b01);

    // Held start in DONE: single return to IDLE
    start = 1'b0; cyc(1);
    start = 1'b1; cyc(1);
    chk("h_idle", done, 0);
    cyc(5);
    chk("h_stay", {running, done}, 2'b00);

    // Clamp
    preset_sec = 6'd63;
    cyc(1);
    chk("clamp_sec", sec, 59);
    chk("clamp_disp", {dsd, dsu}, {7'b0010010, 7'b0010000});

    // Mid-run reset
    preset_sec = 6'd1;
    start = 1'b0; cyc(1);
    start = 1'b1; cyc(1);
    start = 1'b0;
    cyc(5000);
    chk("mr_ms", {sec, ms}, {6'd0, 10'd500});
    rst = 1'b1; cyc(1);
    chk("mr_rst", {running, done, sec, ms}, 18'd0);
    rst = 1'b0; cyc(1);
    chk("mr_reload", sec, 1);

    // Simultaneous start+pause in RUN -> PAUSE
    start = 1'b1; cyc(1);
    start = 1'b0; cyc(3);
    start = 1'b1; pause = 1'b1; cyc(1);
    chk("sp_pause", running, 0);
    cyc(20);
    chk("sp_hold", {sec, ms}, {6'd1, 10'd0});
    start = 1'b0; pause = 1'b0; cyc(1);
    start = 1'b1; cyc(1);
    chk("sp_resume", running, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
